// File: rtl/signed_mult_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : signed_mult_ctrl_if
//  Purpose  : Operand/product handshake plus multiplier-core strobes for
//             signed_mult_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
interface signed_mult_ctrl_if;
    logic        start;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        busy;
    logic [15:0] prod;
    logic        valid;
    logic        err;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        mul_load;
    logic        mul_done;
    logic [15:0] mul_result;

    modport master (
        output start, a_in, b_in, mul_done, mul_result,
        input  busy, prod, valid, err, mul_a, mul_b, mul_load
    );

    modport slave (
        input  start, a_in, b_in, mul_done, mul_result,
        output busy, prod, valid, err, mul_a, mul_b, mul_load
    );
endinterface
`default_nettype wire

// File: rtl/signed_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : signed_mult_ctrl
//  Purpose  : Sign-magnitude wrapper that drives an unsigned 8x8 shift-add
//             multiplier core and returns a signed 16-bit product.
//  Revision : 1.0  initial release
// ============================================================================
module signed_mult_ctrl #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    signed_mult_ctrl_if.slave bus
);
    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_WAIT   = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_accept;
    logic                 w_timeout;
    logic                 r_neg;
    logic                 r_valid;
    logic                 r_err;
    logic [7:0]           r_mul_a;
    logic [7:0]           r_mul_b;
    logic [15:0]          r_prod;
    logic [c_CNT_W-1:0]   r_cnt;

    function automatic logic [7:0] f_mag(input logic [7:0] x);
        return x[7] ? (~x + 8'd1) : x;
    endfunction

    // The completion-pulse cycle is a turnaround: a start seen alongside
    // valid/err waits one more cycle before it is taken.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !r_valid && !r_err) begin
                    w_accept = 1'b1;
                    w_next   = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mul_done) begin
                    w_next = S_SETTLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_SETTLE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_neg   <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_mul_a <= 8'd0;
            r_mul_b <= 8'd0;
            r_prod  <= 16'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_valid <= 1'b0;
            r_err   <= 1'b0;

            if (w_accept) begin
                r_mul_a <= f_mag(bus.a_in);
                r_mul_b <= f_mag(bus.b_in);
                r_neg   <= bus.a_in[7] ^ bus.b_in[7];
            end

            if (r_state == S_WAIT && w_next == S_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            // Core resultant trails its done by a cycle, so it is only
            // trusted at the end of SETTLE.
            if (r_state == S_SETTLE) begin
                r_prod  <= r_neg ? (16'd0 - bus.mul_result) : bus.mul_result;
                r_valid <= 1'b1;
            end else if (w_timeout) begin
                r_prod  <= 16'd0;
                r_err   <= 1'b1;
            end
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.mul_load = (r_state == S_LOAD);
    assign bus.mul_a    = r_mul_a;
    assign bus.mul_b    = r_mul_b;
    assign bus.prod     = r_prod;
    assign bus.valid    = r_valid;
    assign bus.err      = r_err;
endmodule
`default_nettype wire

// File: tb/tb_signed_mult_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_signed_mult_ctrl
//  Purpose  : Self-checking bench for signed_mult_ctrl with an unsigned
//             shift-add core model and a signed-arithmetic reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_signed_mult_ctrl;
    localparam int TIMEOUT_CYC = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    signed_mult_ctrl_if ifc();

    signed_mult_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    function automatic int bitlen(input int v);
        int n = 0;
        while (v > 0) begin
            n++;
            v = v / 2;
        end
        return n;
    endfunction

    function automatic int sval(input logic [7:0] x);
        return int'($signed(x));
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Unsigned core: done one cycle, p+2 cycles after load; result a cycle later.
    int          core_cnt  = 0;
    logic        core_hang = 1'b0;
    logic [15:0] core_prod = 16'd0;

    always @(posedge clk) begin
        if (ifc.mul_load) begin
            core_cnt       <= bitlen(int'(ifc.mul_b)) + 1;
            core_prod      <= 16'(ifc.mul_a) * 16'(ifc.mul_b);
            ifc.mul_result <= 16'($urandom);
            ifc.mul_done   <= 1'b0;
        end else begin
            ifc.mul_done <= (core_cnt == 1) && !core_hang;
            if (core_cnt > 0) core_cnt <= core_cnt - 1;
            if (ifc.mul_done) ifc.mul_result <= core_prod;
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int kind, output int loads,
                          output int first_load, output logic [7:0] seen_a,
                          output logic [7:0] seen_b, output logic [15:0] prod_at,
                          output logic busy_ok, output logic pulse_ok);
        lat = -1; kind = 0; loads = 0; first_load = -1;
        seen_a = 8'd0; seen_b = 8'd0; prod_at = 16'd0;
        busy_ok = 1'b1; pulse_ok = 1'b0;
        ifc.a_in  = a;
        ifc.b_in  = b;
        ifc.start = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (ifc.valid || ifc.err) begin
                lat     = k;
                kind    = ifc.valid ? 1 : 2;
                prod_at = ifc.prod;
                break;
            end
            if (!ifc.busy) busy_ok = 1'b0;
            if (ifc.mul_load) begin
                loads++;
                if (first_load < 0) begin
                    first_load = k;
                    seen_a     = ifc.mul_a;
                    seen_b     = ifc.mul_b;
                end
            end
            @(posedge clk); #1;
        end
        if (kind != 0) begin
            @(posedge clk); #1;
            pulse_ok = !ifc.valid && !ifc.err;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (ifc.busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b want 0", ifc.busy); end
        n_vec++; if (ifc.valid !== 1'b0)    begin n_bad++; $display("FAIL reset_valid: got %b want 0", ifc.valid); end
        n_vec++; if (ifc.err !== 1'b0)      begin n_bad++; $display("FAIL reset_err: got %b want 0", ifc.err); end
        n_vec++; if (ifc.mul_load !== 1'b0) begin n_bad++; $display("FAIL reset_load: got %b want 0", ifc.mul_load); end
        n_vec++; if (ifc.prod !== 16'd0)    begin n_bad++; $display("FAIL reset_prod: got %h want 0000", ifc.prod); end
        n_vec++; if (ifc.mul_a !== 8'd0)    begin n_bad++; $display("FAIL reset_mul_a: got %h want 00", ifc.mul_a); end
        n_vec++; if (ifc.mul_b !== 8'd0)    begin n_bad++; $display("FAIL reset_mul_b: got %h want 00", ifc.mul_b); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [7:0] ta [6] = '{8'hFD, 8'h80, 8'h7F, 8'h00, 8'h09, 8'h02};
        logic [7:0] tb [6] = '{8'h05, 8'h80, 8'h80, 8'hF9, 8'h00, 8'h03};
        for (int i = 0; i < 6; i++) begin
            int lat, kind, loads, fl;
            logic [7:0] sa, sb;
            logic [15:0] pa, ep;
            logic bok, pok;
            int elat;
            ep   = 16'(sval(ta[i]) * sval(tb[i]));
            elat = 4 + bitlen(iabs(sval(tb[i])));
            run_op(ta[i], tb[i], lat, kind, loads, fl, sa, sb, pa, bok, pok);
            n_vec++; if (kind !== 1) begin n_bad++; $display("FAIL dir%0d_valid: got kind %0d want 1", i, kind); end
            n_vec++; if (pa !== ep)  begin n_bad++; $display("FAIL dir%0d_prod: got %h want %h", i, pa, ep); end
            n_vec++; if (lat !== elat) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, elat); end
            n_vec++; if (loads !== 1 || fl !== 0) begin n_bad++; $display("FAIL dir%0d_load: got %0d strobes at %0d want 1 at 0", i, loads, fl); end
            n_vec++; if (sa !== 8'(iabs(sval(ta[i])))) begin n_bad++; $display("FAIL dir%0d_mul_a: got %h want %h", i, sa, 8'(iabs(sval(ta[i])))); end
            n_vec++; if (sb !== 8'(iabs(sval(tb[i])))) begin n_bad++; $display("FAIL dir%0d_mul_b: got %h want %h", i, sb, 8'(iabs(sval(tb[i])))); end
            n_vec++; if (bok !== 1'b1) begin n_bad++; $display("FAIL dir%0d_busy: got dropout want busy throughout", i); end
            n_vec++; if (pok !== 1'b1 || ifc.prod !== ep) begin n_bad++; $display("FAIL dir%0d_pulse_hold: got pulse_ok %b prod %h want 1 %h", i, pok, ifc.prod, ep); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int lat, kind, loads, fl, elat;
            logic [7:0] a, b, sa, sb;
            logic [15:0] pa, ep;
            logic bok, pok;
            a    = 8'($urandom);
            b    = 8'($urandom);
            ep   = 16'(sval(a) * sval(b));
            elat = 4 + bitlen(iabs(sval(b)));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            run_op(a, b, lat, kind, loads, fl, sa, sb, pa, bok, pok);
            n_vec++; if (kind !== 1 || pa !== ep) begin n_bad++; $display("FAIL rnd%0d_prod: a=%h b=%h got kind %0d prod %h want 1 %h", i, a, b, kind, pa, ep); end
            n_vec++; if (lat !== elat) begin n_bad++; $display("FAIL rnd%0d_latency: a=%h b=%h got %0d want %0d", i, a, b, lat, elat); end
            n_vec++; if (sa !== 8'(iabs(sval(a))) || sb !== 8'(iabs(sval(b)))) begin n_bad++; $display("FAIL rnd%0d_mag: got %h/%h want %h/%h", i, sa, sb, 8'(iabs(sval(a))), 8'(iabs(sval(b)))); end
        end
    endtask

    task automatic test_timeout();
        int lat, kind, loads, fl;
        logic [7:0] sa, sb;
        logic [15:0] pa;
        logic bok, pok;
        run_op(8'h03, 8'h04, lat, kind, loads, fl, sa, sb, pa, bok, pok);
        n_vec++; if (pa !== 16'd12) begin n_bad++; $display("FAIL to_pre_prod: got %h want 000c", pa); end
        core_hang = 1'b1;
        run_op(8'h05, 8'h06, lat, kind, loads, fl, sa, sb, pa, bok, pok);
        core_hang = 1'b0;
        n_vec++; if (kind !== 2) begin n_bad++; $display("FAIL to_err: got kind %0d want 2 (err)", kind); end
        n_vec++; if (lat !== TIMEOUT_CYC + 1) begin n_bad++; $display("FAIL to_latency: got %0d want %0d", lat, TIMEOUT_CYC + 1); end
        n_vec++; if (pa !== 16'd0) begin n_bad++; $display("FAIL to_prod: got %h want 0000", pa); end
        n_vec++; if (pok !== 1'b1) begin n_bad++; $display("FAIL to_pulse: got extra pulse want single"); end
    endtask

    task automatic test_back_to_back();
        int k;
        ifc.a_in  = 8'hF9;
        ifc.b_in  = 8'h0B;
        ifc.start = 1'b1;
        @(posedge clk); #1;
        ifc.a_in = 8'h11;
        ifc.b_in = 8'h22;
        k = 0;
        while (!ifc.valid && k < 40) begin @(posedge clk); #1; k++; end
        n_vec++; if (k !== 4 + bitlen(11)) begin n_bad++; $display("FAIL b2b_latency1: got %0d want %0d", k, 4 + bitlen(11)); end
        n_vec++; if (ifc.prod !== 16'(-77)) begin n_bad++; $display("FAIL b2b_prod1: got %h want %h", ifc.prod, 16'(-77)); end
        n_vec++; if (ifc.mul_a !== 8'd7 || ifc.mul_b !== 8'd11) begin n_bad++; $display("FAIL b2b_hold: got %h/%h want 07/0b", ifc.mul_a, ifc.mul_b); end
        @(posedge clk); #1;
        n_vec++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_turnaround: got busy %b want 0", ifc.busy); end
        @(posedge clk); #1;
        n_vec++; if (ifc.mul_load !== 1'b1 || ifc.mul_a !== 8'h11) begin n_bad++; $display("FAIL b2b_accept2: got load %b mul_a %h want 1 11", ifc.mul_load, ifc.mul_a); end
        ifc.start = 1'b0;
        k = 0;
        while (!ifc.valid && k < 40) begin @(posedge clk); #1; k++; end
        n_vec++; if (ifc.prod !== 16'd578 || k !== 4 + bitlen(34)) begin n_bad++; $display("FAIL b2b_op2: got prod %h lat %0d want %h %0d", ifc.prod, k, 16'd578, 4 + bitlen(34)); end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        int lat, kind, loads, fl;
        logic [7:0] sa, sb;
        logic [15:0] pa;
        logic bok, pok;
        ifc.a_in  = 8'd100;
        ifc.b_in  = 8'h9C;
        ifc.start = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (ifc.busy !== 1'b1) begin n_bad++; $display("FAIL mr_busy_before: got %b want 1", ifc.busy); end
        reset = 1'b0;
        #1;
        n_vec++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL mr_busy: got %b want 0", ifc.busy); end
        n_vec++; if (ifc.prod !== 16'd0 || ifc.mul_a !== 8'd0 || ifc.mul_b !== 8'd0) begin n_bad++; $display("FAIL mr_clear: got prod %h a %h b %h want zeros", ifc.prod, ifc.mul_a, ifc.mul_b); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_op(8'h02, 8'h03, lat, kind, loads, fl, sa, sb, pa, bok, pok);
        n_vec++; if (kind !== 1 || pa !== 16'd6) begin n_bad++; $display("FAIL mr_next_prod: got kind %0d prod %h want 1 0006", kind, pa); end
        n_vec++; if (lat !== 6) begin n_bad++; $display("FAIL mr_next_latency: got %0d want 6", lat); end
    endtask

    initial begin
        reset     = 1'b0;
        ifc.start = 1'b0;
        ifc.a_in  = 8'd0;
        ifc.b_in  = 8'd0;
        test_reset();
        test_directed();
        test_random();
        test_timeout();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before 500000ns");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
